// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the core-side transmit/receive signals of the SPI responder.
interface spi_slave_if #(parameter int WIDTH = 8);
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic [WIDTH-1:0] tx_data;
    logic             tx_write;
    logic             tx_empty;
    logic             tx_underrun;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;
    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_write,
        output miso, miso_oe, tx_empty, tx_underrun, rx_data, rx_valid, busy
    );
    modport master (
        output sclk, cs_n, mosi, tx_data, tx_write,
        input  miso, miso_oe, tx_empty, tx_underrun, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: mode-0 MSB-first SPI responder with pins oversampled in raw_clk.
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic        raw_clk_i,
    input logic        reset_i,
    spi_slave_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int CW = $clog2(WIDTH);
    state_t             state_q, state_d;
    logic [SYNC_STAGES:0]   sclk_q, cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]   hold_q, hold_d, rx_data_q, rx_data_d;
    logic               empty_q, empty_d, rx_valid_q, rx_valid_d, underrun_q, underrun_d;
    logic               sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s, load;
    // The last stage of each chain is the "previous" sample used for edge detection.
    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
    assign cs_rise   = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
    assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign load = (state_q == IDLE) ? cs_fall : (!cs_rise && sclk_fall && cnt_q == '0);
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        hold_d     = hold_q;
        empty_d    = empty_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        if (state_q == IDLE) begin
            cnt_d   = '0;
            state_d = cs_fall ? SHIFT : IDLE;
        end else if (cs_rise) begin
            state_d    = IDLE;
            cnt_d      = '0;
            tx_shift_d = '0;
            rx_shift_d = '0;
        end else begin
            if (sclk_rise) begin
                rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d      = '0;
                    rx_data_d  = rx_shift_d;
                    rx_valid_d = 1'b1;
                end
            end
            if (sclk_fall && cnt_q != '0)
                tx_shift_d = tx_shift_q << 1;
        end
        // A load takes the old holding value; a same-cycle write still lands in holding.
        if (load) begin
            tx_shift_d = empty_q ? '0 : hold_q;
            underrun_d = empty_q;
            empty_d    = 1'b1;
        end
        if (bus.tx_write) begin
            hold_d  = bus.tx_data;
            empty_d = 1'b0;
        end
    end
    always_ff @(posedge raw_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            sclk_q     <= '0;
            cs_q       <= '0;
            mosi_q     <= '0;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            hold_q     <= '0;
            empty_q    <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= {sclk_q[SYNC_STAGES-1:0], bus.sclk};
            cs_q       <= {cs_q[SYNC_STAGES-1:0], bus.cs_n};
            mosi_q     <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            hold_q     <= hold_d;
            empty_q    <= empty_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
        end
    end
    assign bus.busy        = (state_q == SHIFT);
    assign bus.miso_oe     = bus.busy;
    assign bus.miso        = bus.busy & tx_shift_q[WIDTH-1];
    assign bus.tx_empty    = empty_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
endmodule
